// File: rtl/pc_fetch_pkg.sv
// Shared types and default vectors for the fetch program-counter unit.
// Imported by pc_fetch_ctrl and pc_redirect_arb.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_e;

    typedef enum logic [2:0] {
        RD_NONE,
        RD_TRAP,
        RD_MRET,
        RD_MISALIGN,
        RD_BRANCH,
        RD_SEQ
    } redirect_src_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0040_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0040_0100;

    // Sources that discard the in-flight fetch stream.
    function automatic logic is_redirect(input redirect_src_e src);
        return (src == RD_TRAP) || (src == RD_MRET) ||
               (src == RD_MISALIGN) || (src == RD_BRANCH);
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational priority encoder choosing the next fetch PC: trap > mret > misaligned branch > branch > sequential.
// Zero latency; no backpressure of its own, the sequential step only happens when the fetch handshake fires.
module pc_redirect_arb
    import pc_fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(DEF_TRAP_VEC),
    parameter int              IALIGN   = 4
) (
    input  logic            trap_req_i,
    input  logic            mret_i,
    input  logic            br_taken_i,
    input  logic [XLEN-1:0] br_target_i,
    input  logic            fetch_fire_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] epc_i,
    output redirect_src_e   src_o,
    output logic [XLEN-1:0] next_pc_o
);

    logic br_misaligned;

    assign br_misaligned = (br_target_i & XLEN'(IALIGN - 1)) != '0;

    always_comb begin
        src_o     = RD_NONE;
        next_pc_o = pc_i;
        if (trap_req_i) begin
            src_o     = RD_TRAP;
            next_pc_o = TRAP_VEC;
        end else if (mret_i) begin
            src_o     = RD_MRET;
            next_pc_o = epc_i;
        end else if (br_taken_i && br_misaligned) begin
            src_o     = RD_MISALIGN;
            next_pc_o = TRAP_VEC;
        end else if (br_taken_i) begin
            src_o     = RD_BRANCH;
            next_pc_o = br_target_i;
        end else if (fetch_fire_i) begin
            src_o     = RD_SEQ;
            next_pc_o = pc_i + XLEN'(IALIGN);
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC register with redirect/trap/mret handling and a BOOT/RUN/HALT debug state machine.
// Redirects land on the next edge with a one-cycle flush; if_pc holds while if_valid && !if_ready.
module pc_fetch_ctrl
    import pc_fetch_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC),
    parameter int              IALIGN    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic [XLEN-1:0] br_pc,
    input  logic            trap_req,
    input  logic [XLEN-1:0] trap_pc,
    input  logic            mret,
    input  logic            halt_req,
    input  logic            resume,
    output logic            flush,
    output logic [XLEN-1:0] epc,
    output logic            misalign,
    output logic [XLEN-1:0] tval,
    output logic            halted
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic            flush_q, flush_d;
    logic            misalign_q, misalign_d;

    redirect_src_e   arb_src;
    logic [XLEN-1:0] arb_pc;

    pc_redirect_arb #(
        .XLEN     (XLEN),
        .TRAP_VEC (TRAP_VEC),
        .IALIGN   (IALIGN)
    ) u_arb (
        .trap_req_i   (trap_req),
        .mret_i       (mret),
        .br_taken_i   (br_taken),
        .br_target_i  (br_target),
        .fetch_fire_i (if_valid && if_ready),
        .pc_i         (pc_q),
        .epc_i        (epc_q),
        .src_o        (arb_src),
        .next_pc_o    (arb_pc)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        tval_d     = tval_q;
        flush_d    = 1'b0;
        misalign_d = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                pc_d    = arb_pc;
                flush_d = is_redirect(arb_src);
                if (arb_src == RD_TRAP) begin
                    epc_d = trap_pc;
                end
                if (arb_src == RD_MISALIGN) begin
                    epc_d      = br_pc;
                    tval_d     = br_target;
                    misalign_d = 1'b1;
                end
                // An accepted fetch still retires its sequential step on the halting cycle.
                if (halt_req && !is_redirect(arb_src)) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                if (resume && !halt_req) begin
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VEC;
            epc_q      <= RESET_VEC;
            tval_q     <= '0;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            tval_q     <= tval_d;
            flush_q    <= flush_d;
            misalign_q <= misalign_d;
        end
    end

    assign if_valid = (state_q == RUN);
    assign halted   = (state_q == HALT);
    assign if_pc    = pc_q;
    assign flush    = flush_q;
    assign misalign = misalign_q;
    assign epc      = epc_q;
    assign tval     = tval_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed vector table for the listed scenarios, then randomized traffic against a behavioural model.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RV = 32'h0040_0000;
    localparam logic [31:0] TV = 32'h0040_0100;
    localparam int          IA = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid, if_ready, br_taken, trap_req, mret, halt_req, resume;
    logic        flush, misalign, halted;
    logic [31:0] if_pc, br_target, br_pc, trap_pc, epc, tval;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_valid  (if_valid),
        .if_ready  (if_ready),
        .if_pc     (if_pc),
        .br_taken  (br_taken),
        .br_target (br_target),
        .br_pc     (br_pc),
        .trap_req  (trap_req),
        .trap_pc   (trap_pc),
        .mret      (mret),
        .halt_req  (halt_req),
        .resume    (resume),
        .flush     (flush),
        .epc       (epc),
        .misalign  (misalign),
        .tval      (tval),
        .halted    (halted)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: mode 0 = booting, 1 = running, 2 = halted.
    int          m_mode;
    logic [31:0] m_pc, m_epc, m_tval;
    logic        m_flush, m_mis;

    typedef struct {
        logic        rdy;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] bpc;
        logic        trap;
        logic [31:0] tpc;
        logic        mr;
        logic        hlt;
        logic        res;
        logic [31:0] e_pc;
        logic        e_vld;
        logic        e_flush;
        logic        e_mis;
        logic        e_halted;
        logic [31:0] e_epc;
        logic [31:0] e_tval;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_vld,
                           input logic e_flush, input logic e_mis, input logic e_halted,
                           input logic [31:0] e_epc, input logic [31:0] e_tval);
        chk({tag, ".if_pc"},    if_pc,    e_pc);
        chk({tag, ".if_valid"}, {31'b0, if_valid}, {31'b0, e_vld});
        chk({tag, ".flush"},    {31'b0, flush},    {31'b0, e_flush});
        chk({tag, ".misalign"}, {31'b0, misalign}, {31'b0, e_mis});
        chk({tag, ".halted"},   {31'b0, halted},   {31'b0, e_halted});
        chk({tag, ".epc"},      epc,      e_epc);
        chk({tag, ".tval"},     tval,     e_tval);
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = RV; m_epc = RV; m_tval = 32'h0; m_flush = 1'b0; m_mis = 1'b0;
    endtask

    // One clock of the rules: priority list for RUN, halt only without a redirect.
    task automatic model_step();
        logic redir;
        redir   = 1'b0;
        m_mis   = 1'b0;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            redir = 1'b1;
            if (trap_req) begin
                m_pc = TV; m_epc = trap_pc;
            end else if (mret) begin
                m_pc = m_epc;
            end else if (br_taken && (br_target % IA) != 0) begin
                m_pc = TV; m_epc = br_pc; m_tval = br_target; m_mis = 1'b1;
            end else if (br_taken) begin
                m_pc = br_target;
            end else begin
                redir = 1'b0;
                if (if_ready) m_pc = m_pc + IA;
            end
            if (halt_req && !redir) m_mode = 2;
        end else begin
            if (resume && !halt_req) m_mode = 1;
        end
        m_flush = redir;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic drive(input logic rdy, input logic br, input logic [31:0] tgt, input logic [31:0] bpc,
                         input logic trap, input logic [31:0] tpc, input logic mr, input logic hlt,
                         input logic res);
        if_ready = rdy; br_taken = br; br_target = tgt; br_pc = bpc;
        trap_req = trap; trap_pc = tpc; mret = mr; halt_req = hlt; resume = res;
    endtask

    task automatic addv(input logic rdy, input logic br, input logic [31:0] tgt, input logic [31:0] bpc,
                        input logic trap, input logic [31:0] tpc, input logic mr, input logic hlt,
                        input logic res, input logic [31:0] e_pc, input logic e_vld, input logic e_flush,
                        input logic e_mis, input logic e_halted, input logic [31:0] e_epc,
                        input logic [31:0] e_tval);
        vec_t v;
        v.rdy = rdy; v.br = br; v.tgt = tgt; v.bpc = bpc; v.trap = trap; v.tpc = tpc;
        v.mr = mr; v.hlt = hlt; v.res = res; v.e_pc = e_pc; v.e_vld = e_vld; v.e_flush = e_flush;
        v.e_mis = e_mis; v.e_halted = e_halted; v.e_epc = e_epc; v.e_tval = e_tval;
        vecs.push_back(v);
    endtask

    task automatic async_reset_check(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk_all(tag, RV, 1'b0, 1'b0, 1'b0, 1'b0, RV, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] t;
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        model_reset();

        //    rdy br tgt           bpc           trp tpc           mr hlt res | pc            vld fl mis hlt epc           tval
        addv(1, 0, 0,            0,            0, 0,            0, 0, 0,   32'h0040_0000, 1, 0, 0, 0, RV,           32'h0);
        addv(1, 0, 0,            0,            0, 0,            0, 0, 0,   32'h0040_0004, 1, 0, 0, 0, RV,           32'h0);
        addv(1, 0, 0,            0,            0, 0,            0, 0, 0,   32'h0040_0008, 1, 0, 0, 0, RV,           32'h0);
        addv(0, 0, 0,            0,            0, 0,            0, 0, 0,   32'h0040_0008, 1, 0, 0, 0, RV,           32'h0);
        addv(0, 0, 0,            0,            0, 0,            0, 0, 0,   32'h0040_0008, 1, 0, 0, 0, RV,           32'h0);
        addv(0, 0, 0,            0,            0, 0,            0, 0, 0,   32'h0040_0008, 1, 0, 0, 0, RV,           32'h0);
        addv(1, 0, 0,            0,            0, 0,            0, 0, 0,   32'h0040_000C, 1, 0, 0, 0, RV,           32'h0);
        addv(0, 1, 32'h0040_0040, 0,           0, 0,            0, 0, 0,   32'h0040_0040, 1, 1, 0, 0, RV,           32'h0);
        addv(0, 0, 0,            0,            0, 0,            0, 0, 0,   32'h0040_0040, 1, 0, 0, 0, RV,           32'h0);
        addv(1, 1, 32'h0040_0042, 32'h0040_0010, 0, 0,          0, 0, 0,   TV,            1, 1, 1, 0, 32'h0040_0010, 32'h0040_0042);
        addv(1, 0, 0,            0,            0, 0,            1, 0, 0,   32'h0040_0010, 1, 1, 0, 0, 32'h0040_0010, 32'h0040_0042);
        addv(1, 1, 32'h0040_0080, 0,           1, 32'h0040_0020, 1, 0, 0,  TV,            1, 1, 0, 0, 32'h0040_0020, 32'h0040_0042);
        addv(1, 1, 32'hFFFF_FFFC, 0,           0, 0,            0, 0, 0,   32'hFFFF_FFFC, 1, 1, 0, 0, 32'h0040_0020, 32'h0040_0042);
        addv(1, 0, 0,            0,            0, 0,            0, 0, 0,   32'h0000_0000, 1, 0, 0, 0, 32'h0040_0020, 32'h0040_0042);
        addv(0, 0, 0,            0,            0, 0,            0, 1, 0,   32'h0000_0000, 0, 0, 0, 1, 32'h0040_0020, 32'h0040_0042);
        addv(1, 1, 32'h0040_0200, 0,           0, 0,            0, 0, 0,   32'h0000_0000, 0, 0, 0, 1, 32'h0040_0020, 32'h0040_0042);
        addv(0, 0, 0,            0,            1, 32'h1234_5678, 0, 0, 0,  32'h0000_0000, 0, 0, 0, 1, 32'h0040_0020, 32'h0040_0042);
        addv(0, 0, 0,            0,            0, 0,            0, 1, 1,   32'h0000_0000, 0, 0, 0, 1, 32'h0040_0020, 32'h0040_0042);
        addv(0, 0, 0,            0,            0, 0,            0, 0, 1,   32'h0000_0000, 1, 0, 0, 0, 32'h0040_0020, 32'h0040_0042);
        addv(0, 1, 32'h0040_0300, 0,           0, 0,            0, 1, 0,   32'h0040_0300, 1, 1, 0, 0, 32'h0040_0020, 32'h0040_0042);
        addv(0, 0, 0,            0,            0, 0,            0, 1, 0,   32'h0040_0300, 0, 0, 0, 1, 32'h0040_0020, 32'h0040_0042);

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", RV, 1'b0, 1'b0, 1'b0, 1'b0, RV, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_all("boot", RV, 1'b0, 1'b0, 1'b0, 1'b0, RV, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rdy, vecs[i].br, vecs[i].tgt, vecs[i].bpc, vecs[i].trap,
                  vecs[i].tpc, vecs[i].mr, vecs[i].hlt, vecs[i].res);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_vld, vecs[i].e_flush,
                    vecs[i].e_mis, vecs[i].e_halted, vecs[i].e_epc, vecs[i].e_tval);
        end

        // Unit is halted here: reset must act without waiting for a clock edge.
        async_reset_check("rst_mid_halt");

        for (int i = 0; i < 600; i++) begin
            if (i == 300) async_reset_check("rst_mid_run");
            t = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) t = t | 32'($urandom_range(1, 3));
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0, t,
                  $urandom & 32'hFFFF_FFFC, $urandom_range(0, 19) == 0,
                  $urandom & 32'hFFFF_FFFC, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 14) == 0, $urandom_range(0, 4) == 0);
            tick();
            chk_all($sformatf("rnd%0d", i), m_pc, m_mode == 1, m_flush, m_mis, m_mode == 2,
                    m_epc, m_tval);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Parametrised program-counter unit for the RV32I core. Successor to the plain PC register.
- Holds the fetch PC and drives it to instruction memory over a valid/ready handshake.
- Adds a stall, branch/jump redirect, trap entry with misaligned-target detection, mret return and a debug halt/resume state machine.
- Sits between the fetch stage and the execute/CSR logic.

Parameters:
- XLEN, 32, PC and address width in bits.
- RESET_VEC, 32'h0040_0000, PC value loaded at reset.
- TRAP_VEC, 32'h0040_0100, PC loaded on trap entry.
- IALIGN, 4, required instruction alignment in bytes (2 or 4). Target bits [log2(IALIGN)-1:0] must be zero.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- if_valid  out  1  fetch request valid.
- if_ready  in  1  instruction memory accepts the request this cycle.
- if_pc  out  XLEN  PC of the current fetch request.
- br_taken  in  1  execute stage requests a redirect.
- br_target  in  XLEN  redirect target.
- br_pc  in  XLEN  PC of the redirecting instruction.
- trap_req  in  1  external or synchronous trap request.
- trap_pc  in  XLEN  PC of the trapping instruction.
- mret  in  1  return from trap.
- halt_req  in  1  debug halt request.
- resume  in  1  debug resume.
- flush  out  1  one-cycle pulse: younger in-flight fetches are invalid.
- epc  out  XLEN  saved exception PC.
- misalign  out  1  one-cycle pulse: a misaligned redirect was converted to a trap.
- tval  out  XLEN  offending target captured on misalign.
- halted  out  1  unit is in HALT.

Behaviour:
- The clock is clk. Reset is asynchronous and active-low on rst_n, and takes effect immediately on assertion.
- Reset values:
  - pc = RESET_VEC, state = BOOT.
  - if_valid = 0, flush = 0, misalign = 0, halted = 0.
  - epc = RESET_VEC, tval = 0.
- State machine:
  - BOOT: one cycle with if_valid = 0, then go to RUN unconditionally.
  - RUN: if_valid = 1.
    - Go to HALT on halt_req, but only when the cycle has no redirect.
    - If halt_req coincides with a redirect, apply the redirect first and re-evaluate halt_req next cycle.
  - HALT: if_valid = 0, halted = 1, pc frozen; all redirect inputs are ignored.
    - resume moves to RUN next cycle with pc unchanged.
    - halt_req and resume together keep the unit in HALT.
- PC update in RUN, fixed priority (highest first):
  1. trap_req: pc <= TRAP_VEC, epc <= trap_pc.
  2. mret: pc <= epc.
  3. br_taken with br_target misaligned: pc <= TRAP_VEC, epc <= br_pc, tval <= br_target, misalign pulses.
  4. br_taken aligned: pc <= br_target.
  5. if_valid && if_ready: pc <= pc + IALIGN (4 when IALIGN = 4). Wraps modulo 2^XLEN with no flag.
  6. Otherwise (stall): pc holds.
- Redirects (1–4):
  - Take effect on the next clock edge regardless of if_ready.
  - Assert flush for exactly that one following cycle.
  - An un-accepted fetch of the old pc is abandoned.
- if_pc equals pc combinationally.
- Handshake rule: while if_valid = 1 and if_ready = 0, if_pc stays stable unless a redirect occurs.
- mret with trap_req in the same cycle: the trap wins, and epc is overwritten with trap_pc.
- Reset mid-operation: all state returns to reset values asynchronously. BOOT is re-entered when rst_n rises.

Decomposition:
- Package pc_fetch_pkg holds:
  - state typedef enum {BOOT, RUN, HALT};
  - redirect-source typedef enum {RD_NONE, RD_TRAP, RD_MRET, RD_MISALIGN, RD_BRANCH, RD_SEQ};
  - the default RESET_VEC and TRAP_VEC constants.
- Sub-module pc_redirect_arb: combinational priority encoder. Takes the requests plus the alignment check and outputs the redirect source and next-pc.
- pc_fetch_ctrl holds the FSM and all registers.

Test Plan:
- Reset, then release rst_n with if_ready = 1 → cycle 0 if_valid = 0, if_pc = 0x0040_0000; if_pc then steps 0x0040_0000, 0x0040_0004, 0x0040_0008.
- Hold if_ready = 0 for 3 cycles at pc 0x0040_0008 → if_pc stays 0x0040_0008 and if_valid stays 1. After if_ready rises, if_pc becomes 0x0040_000C.
- br_taken = 1, br_target = 0x0040_0040, if_ready = 0 → next cycle if_pc = 0x0040_0040, flush = 1 for one cycle.
- br_taken with br_target = 0x0040_0042 and br_pc = 0x0040_0010 → if_pc = 0x0040_0100, epc = 0x0040_0010, tval = 0x0040_0042, misalign pulses. A following mret returns if_pc to 0x0040_0010.
- trap_req with trap_pc = 0x0040_0020, plus mret and br_taken in the same cycle → if_pc = 0x0040_0100, epc = 0x0040_0020, one flush.
- halt_req in RUN → halted = 1 and if_valid = 0 next cycle, with br_taken ignored while halted. resume → if_valid = 1 with an unchanged pc. Asserting rst_n = 0 mid-halt restores if_pc = 0x0040_0000 and halted = 0 immediately.
